// File: rtl/adder_sched_pkg.sv
// Shared types and default constants for the adder scheduler slice.
package adder_sched_pkg;

    localparam int ADDER_WIDTH = 16;
    localparam int ADDER_LAT   = 4;
    // Wide enough to name any of up to 8 requesters.
    localparam int ID_W        = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [ADDER_WIDTH-1:0] sum;
        logic                   cout;
    } resp_t;

endpackage

// File: rtl/adder_resp_fifo.sv
// Synchronous response FIFO. Storage is cleared on reset so the head reads zero.
module adder_resp_fifo
    import adder_sched_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  resp_t         wdata,
    input  logic          pop,
    output resp_t         rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push+pop works even when full.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // A push that finds no room would lose a result.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && full && !pop));
    end

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one pipelined adder among NREQ requesters.
//
// Handshakes: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high; a response transfers on the edge where
// resp_valid and resp_ready are both high. Ready never depends on the same
// cycle's pop, and valid is never withdrawn by the scheduler once raised.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter  int WIDTH      = ADDER_WIDTH,
    parameter  int NREQ       = 4,
    parameter  int ADD_LAT    = ADDER_LAT,
    parameter  int FIFO_DEPTH = 8,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_s,
    input  logic                  add_cout,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  resp_cout
);

    localparam int UW = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0] rr;
    logic [IDW-1:0] gnt_id;
    logic           found;
    logic           issue;
    logic [UW-1:0]  used;
    tag_t           tag_q [ADD_LAT];
    logic           push;
    logic           pop;
    resp_t          push_data;
    resp_t          head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [UW-1:0]  fifo_count;
    int             idx;

    // Search from rr for the first valid requester; gate by credit and reset.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
        issue     = rst_n && found && (used < UW'(FIFO_DEPTH));
        req_ready = issue ? (NREQ'(1) << gnt_id) : '0;
        add_a     = issue ? req_a[int'(gnt_id)*WIDTH +: WIDTH] : '0;
        add_b     = issue ? req_b[int'(gnt_id)*WIDTH +: WIDTH] : '0;
        add_cin   = issue ? req_cin[gnt_id] : 1'b0;
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) rr <= '0;
        else if (issue) rr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end

    // Tag pipeline tracks the adder: last stage lines up with add_s/add_cout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ADD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: issue, id: ID_W'(gnt_id)};
            for (int i = 1; i < ADD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign push      = tag_q[ADD_LAT-1].valid;
    assign push_data = '{id: tag_q[ADD_LAT-1].id, sum: add_s, cout: add_cout};
    assign pop       = resp_valid && resp_ready;

    // Credits cover every op in flight plus every entry waiting in the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) used <= '0;
        else begin
            case ({issue, pop})
                2'b10:   used <= used + UW'(1);
                2'b01:   used <= used - UW'(1);
                default: ;
            endcase
        end
    end

    adder_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign resp_id    = head.id[IDW-1:0];
    assign resp_sum   = head.sum;
    assign resp_cout  = head.cout;

    // Credit bookkeeping invariants: FIFO never holds more than the credits taken.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (fifo_count <= used);
            assert (!fifo_full || used == UW'(FIFO_DEPTH));
            assert (fifo_empty || int'(head.id) < NREQ);
        end
    end

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched with a behavioural 4-stage adder and an
// in-order response scoreboard.
module tb_adder_sched;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int EW   = IDW + 1 + W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_s;
    logic           add_cout;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_sum;
    logic           resp_cout;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int pop_cnt = 0;
    logic [EW-1:0] exp_q[$];
    int grant_log[$];
    logic [W:0] add_pipe [4];

    adder_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .req_ready  (req_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_s      (add_s),
        .add_cout   (add_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural adder: sample at the handshake edge, result after 4 edges.
    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        for (int i = 1; i < 4; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_s    = add_pipe[3][W-1:0];
    assign add_cout = add_pipe[3][W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input string tag, input logic [IDW-1:0] id, input logic [W-1:0] sum, input logic cout);
        for (int n = 0; n < 12 && !resp_valid; n++) step();
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_id"},    32'(resp_id),    32'(id));
        check({tag, "_sum"},   32'(resp_sum),   32'(sum));
        check({tag, "_cout"},  32'(resp_cout),  32'(cout));
        step();
    endtask

    // Scoreboard: record handshakes with a golden sum, check pops in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            checks++;
            assert ($onehot0(req_ready)) else begin
                errors++;
                $error("FAIL onehot: got %b expected at most one bit", req_ready);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic [W:0] s;
                    s = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]} + {{W{1'b0}}, req_cin[i]};
                    exp_q.push_back({IDW'(i), s[W], s[W-1:0]});
                    grant_log.push_back(i);
                    hs_cnt++;
                end
            end
            if (resp_valid && resp_ready) begin
                logic [EW-1:0] e;
                pop_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL sb_unexpected: got id=%0d sum=%h expected no response", resp_id, resp_sum);
                end else begin
                    e = exp_q.pop_front();
                    assert ({resp_id, resp_cout, resp_sum} === e) else begin
                        errors++;
                        $error("FAIL sb_resp: got %h expected %h", {resp_id, resp_cout, resp_sum}, e);
                    end
                end
            end
        end
    end

    initial begin
        int hs0;
        int hs1;
        int p0;
        logic ok;
        logic saw;
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset with requests pending: nothing may be granted.
        rst_n      = 1'b0;
        req_valid  = '1;
        req_a      = {4{16'h1234}};
        req_b      = {4{16'h4321}};
        req_cin    = '1;
        resp_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_sum", 32'(resp_sum), 32'd0);
        check("rst_resp_cout", 32'(resp_cout), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_add_cin", 32'(add_cin), 32'd0);
        check("rst_used", 32'(dut.used), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // Single op from requester 2 and its 5-cycle latency.
        set_req(2, 16'h00FF, 16'h0001, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_add_a", 32'(add_a), 32'h00FF);
        check("single_add_b", 32'(add_b), 32'h0001);
        check("single_add_cin", 32'(add_cin), 32'd0);
        step();
        req_valid = '0;
        repeat (3) step();
        check("single_early", 32'(resp_valid), 32'd0);
        step();
        check("single_valid", 32'(resp_valid), 32'd1);
        check("single_id", 32'(resp_id), 32'd2);
        check("single_sum", 32'(resp_sum), 32'h0100);
        check("single_cout", 32'(resp_cout), 32'd0);
        step();

        // Carry cases; rr now points at 3, so 3 wins before 1.
        set_req(1, 16'hFFFF, 16'h0000, 1'b1);
        set_req(3, 16'h80FF, 16'h8001, 1'b0);
        req_valid = 4'b1010;
        #1;
        check("carry_first_grant", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b0010;
        #1;
        check("carry_second_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        wait_resp("carry_hi", 2'd3, 16'h0100, 1'b1);
        wait_resp("carry_all", 2'd1, 16'h0000, 1'b1);

        // Fairness: all requesters valid for 8 cycles from reset.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 16'(16'h1111 * (i + 1)), 16'(i * 3), i[0]);
        req_valid = '1;
        repeat (8) step();
        req_valid = '0;
        ok = (grant_log.size() == 8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) if (grant_log[i] != exp_order[i]) ok = 1'b0;
        check("fair_order", 32'(ok), 32'd1);
        repeat (12) step();
        check("fair_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: exactly FIFO_DEPTH issues, then a stall.
        do_reset();
        resp_ready = 1'b0;
        hs0 = hs_cnt;
        p0  = pop_cnt;
        req_valid = '1;
        repeat (14) step();
        check("bp_issued", 32'(hs_cnt - hs0), 32'd8);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_used", 32'(dut.used), 32'd8);
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        #1;
        check("bp_no_same_cycle", 32'(req_ready), 32'd0);
        step();
        check("bp_resume_grant", 32'(req_ready), 32'h1);
        hs1 = hs_cnt;
        repeat (7) step();
        check("bp_rate", 32'(hs_cnt - hs1), 32'd7);
        req_valid = '0;
        repeat (25) step();
        check("bp_no_loss", 32'(pop_cnt - p0), 32'(hs_cnt - hs0));
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset two cycles after three issues: those results must vanish.
        do_reset();
        set_req(1, 16'h0A0A, 16'h0505, 1'b1);
        req_valid = 4'b0010;
        repeat (3) step();
        req_valid = '0;
        step();
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        step();
        rst_n     = 1'b1;
        req_valid = '0;
        saw = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (resp_valid) saw = 1'b1;
            step();
        end
        check("mid_rst_no_resp", 32'(saw), 32'd0);
        check("mid_rst_used", 32'(dut.used), 32'd0);
        req_valid = '1;
        #1;
        check("mid_rst_rr", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        repeat (10) step();
        check("mid_rst_drained", 32'(exp_q.size()), 32'd0);

        // Random soak against the scoreboard.
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
            req_valid  = 4'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (30) step();
        check("soak_drained", 32'(exp_q.size()), 32'd0);
        check("soak_idle", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_sched.md
# adder_sched

Round-robin scheduler that shares one 16-bit, 4-stage pipelined staggered adder among NREQ requesters. It accepts one add per cycle from the requesters using a valid/ready handshake and drives the adder's A/B/Cin ports. It tracks each in-flight operation with a tag pipeline that matches the adder latency, and returns each sum, carry and requester id through a credit-protected response FIFO with backpressure. It sits between the requester blocks and the adder instance.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must match the adder.
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 4, adder latency: edges from input sample to a valid S/Cout.
- FIFO_DEPTH, 8, response FIFO entries; must be ≥ ADD_LAT+2 for one op/cycle.

Ports (IDW = clog2(NREQ)). One clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
- req_cin  in  NREQ  carry-in per requester.
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i].
- add_a  out  WIDTH  operand A to the adder.
- add_b  out  WIDTH  operand B to the adder.
- add_cin  out  1  carry-in to the adder.
- add_s  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  requester index of the response.
- resp_sum  out  WIDTH  sum.
- resp_cout  out  1  carry-out.

## Operation
- **Credit counter** `used` (0..FIFO_DEPTH):
  - +1 on issue, -1 on response pop; no change when both occur in one cycle.
  - Issue is allowed only when `used < FIFO_DEPTH`. The decision uses the current `used` value; a same-cycle pop does not enable an issue.
- **Arbitration:**
  - Round-robin pointer `rr`. Search starts at requester `rr`; the first requester with req_valid set is granted.
  - On a grant to requester g, `rr` ← (g+1) mod NREQ. With no grant, `rr` holds.
  - At most one req_ready bit is high per cycle. All req_ready bits are 0 when out of credit or in reset.
- **Adder drive:**
  - add_a/add_b/add_cin are a combinational mux of the granted requester's operands.
  - They are all-zero when nothing is granted.
  - The adder samples them at the same edge that completes the handshake.
- **Tag pipeline:** ADD_LAT stages of {valid, id}.
  - Stage 0 loads {issue, g} every edge; later stages shift.
  - Stage ADD_LAT-1 is aligned with add_s/add_cout.
- **Result capture:** when the last tag stage is valid, {id, add_s, add_cout} is pushed into the FIFO on the next edge.
  - Credit guarantees the FIFO is never full at a push. A push into a full FIFO is a design error; it is asserted in simulation.
- **Response:**
  - resp_* present the FIFO head; resp_valid = !empty.
  - A pop occurs on resp_valid & resp_ready.
  - Responses appear in issue order.
- **Reset (also mid-operation):** clears all tag valids, the FIFO, `used` and `rr` (to 0).
  - Results still inside the adder are discarded, since their tags are invalid.
  - The adder itself has no reset.

## Timing
- Reset values:
  - req_ready = 0, resp_valid = 0.
  - resp_id/resp_sum/resp_cout = 0 (FIFO storage cleared).
  - add_a/add_b/add_cin = 0.
- Latency: handshake at edge k → adder result valid after edge k+ADD_LAT-1 → FIFO write at edge k+ADD_LAT → resp_valid high in the cycle after edge k+ADD_LAT. This is 5 cycles with the defaults.
- Throughput: one issue per cycle while resp_ready=1 and FIFO_DEPTH ≥ ADD_LAT+2.
- Backpressure: with resp_ready=0, exactly FIFO_DEPTH ops are issued, then req_ready stays 0. Issue resumes on the cycle after the first pop.
- Simultaneous FIFO push and pop is supported at any occupancy.

## Structure
- Package `adder_sched_pkg`:
  - default ADD_LAT and WIDTH constants;
  - `tag_t` struct {logic valid; logic [IDW-1:0] id};
  - `resp_t` struct {id, sum, cout}.
- Sub-module `adder_resp_fifo`: synchronous FIFO of `resp_t`, DEPTH parameter, full/empty/count outputs, synchronous active-low reset.
- The round-robin arbiter, tag pipeline and credit counter live in the top module.

## Test plan
- **Single op:** requester 2 sends A=0x00FF, B=0x0001, Cin=0 at edge k → resp_valid after edge k+4 with id=2, sum=0x0100, cout=0.
- **Carry across halves:** A=0xFFFF, B=0x0000, Cin=1 → sum=0x0000, cout=1; A=0x80FF, B=0x8001, Cin=0 → sum=0x0100, cout=1.
- **Fairness:** all 4 requesters hold valid for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3, and responses return in that id order.
- **Backpressure:** resp_ready=0 with all requesters valid → exactly 8 handshakes, then req_ready=0. Raising resp_ready → one new grant per cycle resumes, with no lost or duplicated responses.
- **Reset mid-flight:** issue 3 ops, assert rst_n=0 for one edge two cycles later → no resp_valid ever for those ops, `used`=0, and the next grant goes to requester 0.
- **Random soak:** random valid/ready and operands against a golden model → the sum/cout/id stream matches, with in-order per-issue delivery.
